// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two request channels.
// Each granted transaction is issued with a one-cycle strobe and completes after a
// fixed read or write latency with a one-cycle ready pulse on the owning channel.
module mem_channel_arbiter #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int SIZE_W      = 6,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_oe,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  input  logic [2*SIZE_W-1:0]   req_size,
  output logic [2*DATA_W-1:0]   rsp_rdata,
  output logic [1:0]            rsp_rdy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_mask,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  err
);

  localparam int MAX_D = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CNT_W = $clog2(MAX_D + 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_DELAY - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                ch_reg, ch_next;
  logic                op_reg, op_next;          // 1 = write
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   mask_reg, mask_next;
  logic                last_grant_reg, last_grant_next;
  logic [DATA_W-1:0]   hold_reg;
  logic                err_reg;

  logic [1:0]          eligible;
  logic [1:0]          conflict;
  logic [ADDR_W-1:0]   ch_addr  [2];
  logic [DATA_W-1:0]   ch_wdata [2];
  logic [SIZE_W-1:0]   ch_size  [2];
  logic                grant_valid;
  logic                grant_ch;
  logic [SIZE_W-1:0]   sel_size;
  logic [DATA_W-1:0]   grant_mask;
  logic [CNT_W-1:0]    op_last;

  // Per-channel request decode: a channel is eligible only with exactly one of oe/we.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign eligible[gi] = req_oe[gi] ^ req_we[gi];
      assign conflict[gi] = req_oe[gi] & req_we[gi];
      assign ch_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign ch_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
      assign ch_size[gi]  = req_size[gi*SIZE_W +: SIZE_W];
    end
  endgenerate

  // With both eligible the channel that did not win last time is chosen.
  assign grant_valid = |eligible;
  assign grant_ch    = (eligible == 2'b11) ? ~last_grant_reg : eligible[1];
  assign sel_size    = ch_size[grant_ch];

  // Bit b of the mask is set when size > b: (1<<size)-1, saturating at all ones.
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_mask
      assign grant_mask[gi] = (32'(sel_size) > gi);
    end
  endgenerate

  assign op_last = op_reg ? WR_LAST : RD_LAST;

  // Next-state logic: grant and latch in IDLE, count latency, release in DONE.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    ch_next         = ch_reg;
    op_next         = op_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    mask_next       = mask_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          ch_next    = grant_ch;
          op_next    = req_we[grant_ch];
          addr_next  = ch_addr[grant_ch];
          wdata_next = ch_wdata[grant_ch];
          mask_next  = grant_mask;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = CNT_ONE;
        state_next = (op_last == '0) ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_reg == op_last) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      DONE: begin
        last_grant_next = ch_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and latched-request registers; reset favours channel 0 for the first grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      ch_reg         <= 1'b0;
      op_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      mask_reg       <= '0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      ch_reg         <= ch_next;
      op_reg         <= op_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      mask_reg       <= mask_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Read data is valid only the cycle after issue; hold it until DONE. Conflicts are sticky.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (|conflict) begin
        err_reg <= 1'b1;
      end
      if (state_reg == WAIT && cnt_reg == CNT_ONE && !op_reg) begin
        hold_reg <= mem_rdata;
      end
    end
  end

  // Memory side is driven only during ISSUE.
  assign mem_en    = (state_reg == ISSUE);
  assign mem_we    = mem_en & op_reg;
  assign mem_addr  = mem_en ? addr_reg  : '0;
  assign mem_wdata = mem_en ? wdata_reg : '0;
  assign mem_mask  = mem_en ? mask_reg  : '0;
  assign err       = err_reg;

  // Response side is driven only during DONE, on the owning channel's slice.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      assign rsp_rdy[gi] = (state_reg == DONE) && (ch_reg == 1'(gi));
      assign rsp_rdata[gi*DATA_W +: DATA_W] = (rsp_rdy[gi] && !op_reg) ? hold_reg : '0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: a default-latency instance plus a
// READ_DELAY=4 / WRITE_DELAY=3 instance, each with a synchronous memory model that
// presents read data only in the cycle after a read issue.
module tb_mem_channel_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_oe, req_we;
  logic [17:0] req_addr;
  logic [63:0] req_wdata;
  logic [11:0] req_size;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_rdy;
  logic        mem_en, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_mask, mem_rdata;
  logic        err;

  logic [1:0]  s_req_oe, s_req_we;
  logic [17:0] s_req_addr;
  logic [63:0] s_req_wdata;
  logic [11:0] s_req_size;
  logic [63:0] s_rsp_rdata;
  logic [1:0]  s_rsp_rdy;
  logic        s_mem_en, s_mem_we;
  logic [8:0]  s_mem_addr;
  logic [31:0] s_mem_wdata, s_mem_mask, s_mem_rdata;
  logic        s_err;

  logic [31:0] mem [512];
  logic [31:0] last_wr;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_channel_arbiter u_dut (
    .clock(clk), .reset(reset),
    .req_oe(req_oe), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .rsp_rdata(rsp_rdata), .rsp_rdy(rsp_rdy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
    .err(err)
  );

  mem_channel_arbiter #(.READ_DELAY(4), .WRITE_DELAY(3)) u_slow (
    .clock(clk), .reset(reset),
    .req_oe(s_req_oe), .req_we(s_req_we), .req_addr(s_req_addr),
    .req_wdata(s_req_wdata), .req_size(s_req_size),
    .rsp_rdata(s_rsp_rdata), .rsp_rdy(s_rsp_rdy),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_mask(s_mem_mask), .mem_rdata(s_mem_rdata),
    .err(s_err)
  );

  // Memory models: read data appears one cycle after a read issue, garbage otherwise.
  always @(posedge clk) begin
    mem_rdata   <= (mem_en && !mem_we) ? mem[mem_addr] : 32'h0BAD_F00D;
    s_mem_rdata <= (s_mem_en && !s_mem_we) ? mem[s_mem_addr] : 32'h0BAD_F00D;
    if (mem_en && mem_we) last_wr <= (mem[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_oe = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0;
    s_req_oe = 0; s_req_we = 0; s_req_addr = 0; s_req_wdata = 0; s_req_size = 0;
    step(); step();
    total++; if (rsp_rdy !== 2'b00) begin bad++; $display("FAIL reset_rsp_rdy got=%b exp=00", rsp_rdy); end
    total++; if (rsp_rdata !== 64'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 9'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_mask !== 32'h0) begin bad++; $display("FAIL reset_mem_mask got=%h exp=0", mem_mask); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (s_mem_en !== 1'b0 || s_rsp_rdy !== 2'b00) begin bad++; $display("FAIL reset_slow got en=%b rdy=%b exp 0/00", s_mem_en, s_rsp_rdy); end
    reset = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_read();
    req_addr[8:0] = 9'h010; req_size[5:0] = 6'd32; req_oe = 2'b01;
    step(); // issue cycle
    total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL read_issue_en got=%b exp=1", mem_en); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL read_issue_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 9'h010) begin bad++; $display("FAIL read_issue_addr got=%h exp=010", mem_addr); end
    total++; if (rsp_rdy !== 2'b00) begin bad++; $display("FAIL read_c1_rdy got=%b exp=00", rsp_rdy); end
    step();
    total++; if (mem_en !== 1'b0 || rsp_rdy !== 2'b00) begin bad++; $display("FAIL read_c2 got en=%b rdy=%b exp 0/00", mem_en, rsp_rdy); end
    step();
    total++; if (rsp_rdy !== 2'b01) begin bad++; $display("FAIL read_c3_rdy got=%b exp=01", rsp_rdy); end
    total++; if (rsp_rdata !== 64'h0000_0000_DEAD_BEEF) begin bad++; $display("FAIL read_c3_data got=%h exp=00000000deadbeef", rsp_rdata); end
    req_oe = 2'b00;
    step();
    total++; if (rsp_rdy !== 2'b00 || rsp_rdata !== 64'h0) begin bad++; $display("FAIL read_c4_idle got rdy=%b data=%h exp 00/0", rsp_rdy, rsp_rdata); end
    $display("txn read ch0 addr=010 data=%h", 32'hDEADBEEF);
  endtask

  task automatic test_write();
    req_addr[17:9] = 9'h020; req_wdata[63:32] = 32'h1234_5678; req_size[11:6] = 6'd8; req_we = 2'b10;
    step();
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL write_issue got en=%b we=%b exp 1/1", mem_en, mem_we); end
    total++; if (mem_addr !== 9'h020) begin bad++; $display("FAIL write_addr got=%h exp=020", mem_addr); end
    total++; if (mem_wdata !== 32'h1234_5678) begin bad++; $display("FAIL write_wdata got=%h exp=12345678", mem_wdata); end
    total++; if (mem_mask !== 32'h0000_00FF) begin bad++; $display("FAIL write_mask got=%h exp=000000ff", mem_mask); end
    total++; if (rsp_rdy !== 2'b00) begin bad++; $display("FAIL write_c1_rdy got=%b exp=00", rsp_rdy); end
    step();
    total++; if (rsp_rdy !== 2'b10) begin bad++; $display("FAIL write_c2_rdy got=%b exp=10", rsp_rdy); end
    total++; if (rsp_rdata !== 64'h0) begin bad++; $display("FAIL write_rdata got=%h exp=0", rsp_rdata); end
    total++; if (last_wr !== 32'hAAAA_AA78) begin bad++; $display("FAIL write_merge got=%h exp=aaaaaa78", last_wr); end
    req_we = 2'b00;
    step();
    total++; if (rsp_rdy !== 2'b00 || mem_en !== 1'b0) begin bad++; $display("FAIL write_c3_idle got rdy=%b en=%b exp 00/0", rsp_rdy, mem_en); end
    $display("txn write ch1 addr=020 data=12345678 size=8");
  endtask

  task automatic test_zero_size();
    req_addr[8:0] = 9'h020; req_wdata[31:0] = 32'hFFFF_FFFF; req_size[5:0] = 6'd0; req_we = 2'b01;
    step();
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL zsize_issue got en=%b we=%b exp 1/1", mem_en, mem_we); end
    total++; if (mem_mask !== 32'h0) begin bad++; $display("FAIL zsize_mask got=%h exp=0", mem_mask); end
    step();
    total++; if (rsp_rdy !== 2'b01) begin bad++; $display("FAIL zsize_rdy got=%b exp=01", rsp_rdy); end
    total++; if (last_wr !== 32'hAAAA_AAAA) begin bad++; $display("FAIL zsize_merge got=%h exp=aaaaaaaa", last_wr); end
    req_we = 2'b00;
    step();
    $display("txn write ch0 addr=020 size=0");
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic [63:0] exp_data;
    do_reset();
    req_we = 2'b00; req_size = 12'd0;
    req_addr = {9'h040, 9'h030}; req_oe = 2'b11;
    for (int c = 1; c <= 16; c++) begin
      step();
      exp_rdy  = (c == 3 || c == 11) ? 2'b01 : (c == 7 || c == 15) ? 2'b10 : 2'b00;
      exp_data = (exp_rdy == 2'b01) ? 64'h0000_0000_3030_3030 :
                 (exp_rdy == 2'b10) ? 64'h4040_4040_0000_0000 : 64'h0;
      total++; if (mem_en !== (c % 4 == 1)) begin bad++; $display("FAIL rr_en c=%0d got=%b exp=%b", c, mem_en, (c % 4 == 1)); end
      total++; if (rsp_rdy !== exp_rdy) begin bad++; $display("FAIL rr_rdy c=%0d got=%b exp=%b", c, rsp_rdy, exp_rdy); end
      total++; if (rsp_rdata !== exp_data) begin bad++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, rsp_rdata, exp_data); end
      if (exp_rdy != 2'b00) $display("txn rr read rdy=%b cycle=%0d", exp_rdy, c);
    end
    req_oe = 2'b00;
    step();
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rr_stop_en got=%b exp=0", mem_en); end
  endtask

  task automatic test_conflict();
    do_reset();
    req_addr[17:9] = 9'h040; req_oe = 2'b11; req_we = 2'b01;
    step();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL conf_err got=%b exp=1", err); end
    total++; if (mem_en !== 1'b1 || mem_addr !== 9'h040) begin bad++; $display("FAIL conf_grant got en=%b addr=%h exp 1/040", mem_en, mem_addr); end
    step(); step();
    total++; if (rsp_rdy !== 2'b10) begin bad++; $display("FAIL conf_rdy got=%b exp=10", rsp_rdy); end
    total++; if (rsp_rdata !== 64'h4040_4040_0000_0000) begin bad++; $display("FAIL conf_data got=%h exp=4040404000000000", rsp_rdata); end
    req_oe = 2'b01;
    for (int c = 0; c < 4; c++) begin
      step();
      total++; if (mem_en !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL conf_block c=%0d got en=%b err=%b exp 0/1", c, mem_en, err); end
    end
    req_oe = 2'b00; req_we = 2'b00;
    step();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL conf_sticky got=%b exp=1", err); end
    $display("txn conflict ch0, read ch1 addr=040");
  endtask

  task automatic test_reset_mid();
    req_addr[8:0] = 9'h010; req_oe = 2'b01;
    step();
    total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL rmid_issue got=%b exp=1", mem_en); end
    step(); // WAIT
    reset = 1'b1; req_oe = 2'b00;
    step();
    total++; if (rsp_rdy !== 2'b00 || rsp_rdata !== 64'h0) begin bad++; $display("FAIL rmid_rsp got rdy=%b data=%h exp 00/0", rsp_rdy, rsp_rdata); end
    total++; if (mem_en !== 1'b0 || mem_addr !== 9'h0) begin bad++; $display("FAIL rmid_mem got en=%b addr=%h exp 0/0", mem_en, mem_addr); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b exp=0", err); end
    reset = 1'b0;
    step();
    total++; if (rsp_rdy !== 2'b00) begin bad++; $display("FAIL rmid_after got=%b exp=00", rsp_rdy); end
    req_oe = 2'b01;
    step();
    total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL rmid_new_issue got=%b exp=1", mem_en); end
    step();
    total++; if (rsp_rdy !== 2'b00) begin bad++; $display("FAIL rmid_new_c2 got=%b exp=00", rsp_rdy); end
    step();
    total++; if (rsp_rdy !== 2'b01 || rsp_rdata[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rmid_new_done got rdy=%b data=%h exp 01/deadbeef", rsp_rdy, rsp_rdata[31:0]); end
    req_oe = 2'b00;
    step();
    $display("txn reset mid-read then read ch0 addr=010");
  endtask

  task automatic test_slow();
    s_req_addr[8:0] = 9'h010; s_req_oe = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      step();
      total++; if (s_mem_en !== (c == 1)) begin bad++; $display("FAIL slow_rd_en c=%0d got=%b exp=%b", c, s_mem_en, (c == 1)); end
      total++; if (s_rsp_rdy !== ((c == 5) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL slow_rd_rdy c=%0d got=%b", c, s_rsp_rdy); end
    end
    total++; if (s_rsp_rdata !== 64'h0000_0000_DEAD_BEEF) begin bad++; $display("FAIL slow_rd_data got=%h exp=00000000deadbeef", s_rsp_rdata); end
    s_req_oe = 2'b00;
    step();
    $display("txn slow read ch0 addr=010");
    s_req_addr[17:9] = 9'h050; s_req_wdata[63:32] = 32'h55AA_55AA; s_req_size[11:6] = 6'd40; s_req_we = 2'b10;
    for (int c = 1; c <= 4; c++) begin
      step();
      total++; if (s_mem_en !== (c == 1)) begin bad++; $display("FAIL slow_wr_en c=%0d got=%b exp=%b", c, s_mem_en, (c == 1)); end
      total++; if (s_rsp_rdy !== ((c == 4) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL slow_wr_rdy c=%0d got=%b", c, s_rsp_rdy); end
      if (c == 1) begin
        total++; if (s_mem_we !== 1'b1 || s_mem_mask !== 32'hFFFF_FFFF) begin bad++; $display("FAIL slow_wr_issue got we=%b mask=%h exp 1/ffffffff", s_mem_we, s_mem_mask); end
      end
    end
    s_req_we = 2'b00;
    step();
    $display("txn slow write ch1 addr=050 size=40");
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[9'h010] = 32'hDEAD_BEEF;
    mem[9'h020] = 32'hAAAA_AAAA;
    mem[9'h030] = 32'h3030_3030;
    mem[9'h040] = 32'h4040_4040;
    test_reset();
    test_read();
    test_write();
    test_zero_size();
    test_round_robin();
    test_conflict();
    test_reset_mid();
    test_slow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
